bus_arb: RTL and testbench

Backplane bus arbiter between the KS10 CPU, the console interface and the Unibus adapter (UBA). Accepts one outstanding request per master, grants the single shared memory/IO bus to one master at a time, forwards that master's address/flags and write data, and returns the slave acknowledge and read data to the owner only. Sits directly downstream of the CPU's bus request outputs and supplies its acknowledge and read-data inputs.

---
 rtl/bus_arb_if.sv | 37 +++
 rtl/bus_arb.sv | 108 ++++++++++
 tb/tb_bus_arb.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arb_if.sv
// Signal bundle between the CPU/console/UBA masters, the backplane arbiter
// and the shared memory/IO slave.
interface bus_arb_if;
    logic        cslREQI,  ubaREQI,  cpuREQI;
    logic [0:35] cslADDRI, ubaADDRI, cpuADDRI;
    logic [0:35] cslDATAI, ubaDATAI, cpuDATAI;
    logic        cslACKO,  ubaACKO,  cpuACKO;
    logic [0:35] arbDATAO;
    logic        busREQO;
    logic [0:35] busADDRO;
    logic [0:35] busDATAO;
    logic        busACKI;
    logic [0:35] busDATAI;
    logic [0:2]  arbGRANT;
    logic        arbTIMEOUT;

    // slave: the arbiter itself; master: the requesting masters plus the backplane slave
    modport slave (
        input  cslREQI, ubaREQI, cpuREQI,
        input  cslADDRI, ubaADDRI, cpuADDRI,
        input  cslDATAI, ubaDATAI, cpuDATAI,
        input  busACKI, busDATAI,
        output cslACKO, ubaACKO, cpuACKO,
        output arbDATAO, busREQO, busADDRO, busDATAO,
        output arbGRANT, arbTIMEOUT
    );

    modport master (
        output cslREQI, ubaREQI, cpuREQI,
        output cslADDRI, ubaADDRI, cpuADDRI,
        output cslDATAI, ubaDATAI, cpuDATAI,
        output busACKI, busDATAI,
        input  cslACKO, ubaACKO, cpuACKO,
        input  arbDATAO, busREQO, busADDRO, busDATAO,
        input  arbGRANT, arbTIMEOUT
    );
endinterface

// File: rtl/bus_arb.sv
// Backplane arbiter: console has fixed top priority, UBA and CPU rotate;
// a master whose transaction times out is locked out until it drops REQ.
module bus_arb #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic     clk,
    input  logic     rst,
    bus_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} arbState;

    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

    arbState     state, stateNext;
    logic [0:2]  grant, grantNext;
    logic [0:2]  ack, ackNext;
    logic [0:2]  block, blockNext;
    logic [0:2]  reqLive, reqMasked;
    logic [15:0] waitCnt, waitCntNext;
    logic [0:35] rdData, rdDataNext;
    logic        timeoutHit, timeoutHitNext;
    logic        lastUba, lastUbaNext;

    assign bus.arbGRANT   = grant;
    assign bus.cslACKO    = ack[0];
    assign bus.ubaACKO    = ack[1];
    assign bus.cpuACKO    = ack[2];
    assign bus.arbDATAO   = rdData;
    assign bus.arbTIMEOUT = timeoutHit;
    assign bus.busREQO    = (state == BUSY);
    assign bus.busADDRO   = ({36{grant[0]}} & bus.cslADDRI)
                          | ({36{grant[1]}} & bus.ubaADDRI)
                          | ({36{grant[2]}} & bus.cpuADDRI);
    assign bus.busDATAO   = ({36{grant[0]}} & bus.cslDATAI)
                          | ({36{grant[1]}} & bus.ubaDATAI)
                          | ({36{grant[2]}} & bus.cpuDATAI);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            ack        <= '0;
            block      <= '0;
            waitCnt    <= '0;
            rdData     <= '0;
            timeoutHit <= 1'b0;
            lastUba    <= 1'b0;
        end else begin
            state      <= stateNext;
            grant      <= grantNext;
            ack        <= ackNext;
            block      <= blockNext;
            waitCnt    <= waitCntNext;
            rdData     <= rdDataNext;
            timeoutHit <= timeoutHitNext;
            lastUba    <= lastUbaNext;
        end
    end

    always_comb begin
        stateNext      = state;
        grantNext      = grant;
        ackNext        = '0;
        waitCntNext    = waitCnt;
        rdDataNext     = rdData;
        timeoutHitNext = 1'b0;
        lastUbaNext    = lastUba;
        reqLive        = {bus.cslREQI, bus.ubaREQI, bus.cpuREQI};
        reqMasked      = reqLive & ~block;
        blockNext      = block & reqLive;

        case (state)
            IDLE: begin
                if (|reqMasked) begin
                    stateNext   = BUSY;
                    waitCntNext = '0;
                    if (reqMasked[0]) begin
                        grantNext = 3'b100;
                    end else if (reqMasked[1] && (!reqMasked[2] || !lastUba)) begin
                        grantNext   = 3'b010;
                        lastUbaNext = 1'b1;
                    end else begin
                        grantNext   = 3'b001;
                        lastUbaNext = 1'b0;
                    end
                end
            end
            BUSY: begin
                // ACK takes precedence over a timeout landing in the same cycle
                if (bus.busACKI) begin
                    rdDataNext = bus.busDATAI;
                    ackNext    = grant;
                    grantNext  = '0;
                    stateNext  = RELEASE;
                end else if (waitCnt == WAIT_LIMIT) begin
                    timeoutHitNext = 1'b1;
                    blockNext      = (block | grant) & reqLive;
                    grantNext      = '0;
                    stateNext      = RELEASE;
                end else if (waitCnt != '1) begin
                    waitCntNext = waitCnt + 16'd1;
                end
            end
            RELEASE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb: cycle-exact checks plus a scoreboard of
// expected ACK/timeout events popped when the DUT reports them.
module tb_bus_arb;
    logic clk = 1'b0;
    logic rst;
    int unsigned passCnt  = 0;
    int unsigned failCnt  = 0;
    int unsigned totalCnt = 0;

    typedef struct {
        logic [2:0]  ack;
        logic        to;
        logic [35:0] data;
    } expEvt;
    expEvt expQ[$];

    bus_arb_if bus ();
    bus_arb #(.TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectEvt(input logic [2:0] a, input logic t, input logic [35:0] d);
        expEvt e;
        e.ack  = a;
        e.to   = t;
        e.data = d;
        expQ.push_back(e);
    endtask

    function automatic logic [2:0] ackBits();
        return {bus.cslACKO, bus.ubaACKO, bus.cpuACKO};
    endfunction

    task automatic waitGrant(output logic [2:0] g);
        g = 3'b000;
        for (int i = 0; i < 20; i++) begin
            if (bus.arbGRANT != 3'b000) begin
                g = bus.arbGRANT;
                break;
            end
            tick();
        end
    endtask

    task automatic checkIdle(input string tag);
        check({tag, ".grant"},   36'(bus.arbGRANT),   36'd0);
        check({tag, ".busReq"},  36'(bus.busREQO),    36'd0);
        check({tag, ".ack"},     36'(ackBits()),      36'd0);
        check({tag, ".timeout"}, 36'(bus.arbTIMEOUT), 36'd0);
        check({tag, ".arbData"}, 36'(bus.arbDATAO),   36'd0);
        check({tag, ".busAddr"}, 36'(bus.busADDRO),   36'd0);
    endtask

    // scoreboard: every ACK or timeout pulse must match the next expected event
    always @(negedge clk) begin
        expEvt e;
        if (ackBits() != 3'b000 || bus.arbTIMEOUT) begin
            if (expQ.size() == 0) begin
                check("sbUnexpected", 36'({ackBits(), bus.arbTIMEOUT}), 36'd0);
            end else begin
                e = expQ.pop_front();
                check("sbAck", 36'(ackBits()), 36'(e.ack));
                check("sbTimeout", 36'(bus.arbTIMEOUT), 36'(e.to));
                if (e.ack != 3'b000) check("sbData", 36'(bus.arbDATAO), e.data);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed no finish, expected finish before 50000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  g;
        logic [2:0]  order [3];
        logic [35:0] addrs [3];
        logic [35:0] datas [3];
        logic [2:0]  rotExp;

        rst = 1'b1;
        bus.cslREQI = 1'b0; bus.ubaREQI = 1'b0; bus.cpuREQI = 1'b0;
        bus.cslADDRI = 36'o100000000001; bus.ubaADDRI = 36'o200000000002;
        bus.cpuADDRI = 36'o400000001000;
        bus.cslDATAI = 36'o111111111111; bus.ubaDATAI = 36'o222222222222;
        bus.cpuDATAI = 36'o777000111222;
        bus.busACKI = 1'b0; bus.busDATAI = '0;
        repeat (3) tick();
        checkIdle("reset");
        rst = 1'b0;
        tick();

        // ACK while idle must not produce ACKO or load read data
        bus.busACKI = 1'b1; bus.busDATAI = 36'hFFFFFFFFF;
        tick(); tick();
        check("idleAckData", 36'(bus.arbDATAO), 36'd0);
        bus.busACKI = 1'b0; bus.busDATAI = '0;
        tick();

        // single CPU read, cycle 0 = now
        bus.cpuREQI = 1'b1;
        expectEvt(3'b001, 1'b0, 36'o123456701234);
        tick();
        check("c1.grant",   36'(bus.arbGRANT), 36'(3'b001));
        check("c1.busReq",  36'(bus.busREQO),  36'd1);
        check("c1.busAddr", 36'(bus.busADDRO), 36'o400000001000);
        check("c1.busData", 36'(bus.busDATAO), 36'o777000111222);
        tick();
        check("c2.grant", 36'(bus.arbGRANT), 36'(3'b001));
        tick();
        check("c3.grant", 36'(bus.arbGRANT), 36'(3'b001));
        bus.busACKI = 1'b1; bus.busDATAI = 36'o123456701234;
        tick();
        check("c4.cpuAck",  36'(bus.cpuACKO),  36'd1);
        check("c4.arbData", 36'(bus.arbDATAO), 36'o123456701234);
        check("c4.grant",   36'(bus.arbGRANT), 36'd0);
        check("c4.busReq",  36'(bus.busREQO),  36'd0);
        bus.busACKI = 1'b0; bus.busDATAI = '0; bus.cpuREQI = 1'b0;
        tick();
        check("c5.grant",  36'(bus.arbGRANT), 36'd0);
        check("c5.cpuAck", 36'(bus.cpuACKO),  36'd0);
        tick();

        // simultaneous requests: console, then UBA, then CPU
        order[0] = 3'b100; order[1] = 3'b010; order[2] = 3'b001;
        addrs[0] = bus.cslADDRI; addrs[1] = bus.ubaADDRI; addrs[2] = bus.cpuADDRI;
        datas[0] = 36'o010101010101; datas[1] = 36'o020202020202; datas[2] = 36'o030303030303;
        bus.cslREQI = 1'b1; bus.ubaREQI = 1'b1; bus.cpuREQI = 1'b1;
        for (int k = 0; k < 3; k++) expectEvt(order[k], 1'b0, datas[k]);
        for (int k = 0; k < 3; k++) begin
            waitGrant(g);
            check("simulOrder", 36'(g), 36'(order[k]));
            check("simulAddr", 36'(bus.busADDRO), addrs[k]);
            tick();
            bus.busACKI = 1'b1; bus.busDATAI = datas[k];
            tick();
            bus.busACKI = 1'b0; bus.busDATAI = '0;
            if (g[2]) bus.cslREQI = 1'b0;
            if (g[1]) bus.ubaREQI = 1'b0;
            if (g[0]) bus.cpuREQI = 1'b0;
        end
        tick(); tick();

        // UBA and CPU requesting continuously: strict alternation from UBA
        bus.ubaREQI = 1'b1; bus.cpuREQI = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rotExp = (i % 2 == 0) ? 3'b010 : 3'b001;
            expectEvt(rotExp, 1'b0, 36'h0ABC00000 + 36'(i));
        end
        for (int i = 0; i < 8; i++) begin
            rotExp = (i % 2 == 0) ? 3'b010 : 3'b001;
            waitGrant(g);
            check("rotate", 36'(g), 36'(rotExp));
            tick();
            bus.busACKI = 1'b1; bus.busDATAI = 36'h0ABC00000 + 36'(i);
            tick();
            bus.busACKI = 1'b0; bus.busDATAI = '0;
        end
        bus.ubaREQI = 1'b0; bus.cpuREQI = 1'b0;
        tick(); tick();

        // timeout: grant in cycle 1, abort pulse in cycle 9, lockout until REQ drops
        bus.cpuREQI = 1'b1;
        expectEvt(3'b000, 1'b1, 36'd0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("toGrant", 36'(bus.arbGRANT), 36'(3'b001));
            check("toEarly", 36'(bus.arbTIMEOUT), 36'd0);
        end
        tick();
        check("toPulse",  36'(bus.arbTIMEOUT), 36'd1);
        check("toNoAck",  36'(bus.cpuACKO),    36'd0);
        check("toGrant0", 36'(bus.arbGRANT),   36'd0);
        for (int c = 10; c <= 15; c++) begin
            tick();
            check("blocked", 36'(bus.arbGRANT), 36'd0);
        end
        bus.cpuREQI = 1'b0;
        tick();
        check("dropGrant", 36'(bus.arbGRANT), 36'd0);
        bus.cpuREQI = 1'b1;
        tick();
        check("regrantAfterDrop", 36'(bus.arbGRANT), 36'(3'b001));
        expectEvt(3'b001, 1'b0, 36'o555555555555);
        bus.busACKI = 1'b1; bus.busDATAI = 36'o555555555555;
        tick();
        check("regrantAck", 36'(bus.cpuACKO), 36'd1);
        bus.busACKI = 1'b0; bus.busDATAI = '0; bus.cpuREQI = 1'b0;
        tick(); tick();

        // ACK in the same cycle the counter reaches TIMEOUT-1
        bus.cpuREQI = 1'b1;
        expectEvt(3'b001, 1'b0, 36'o707070707070);
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("edgeGrant", 36'(bus.arbGRANT), 36'(3'b001));
        end
        bus.busACKI = 1'b1; bus.busDATAI = 36'o707070707070;
        tick();
        check("edgeAck",     36'(bus.cpuACKO),    36'd1);
        check("edgeNoTo",    36'(bus.arbTIMEOUT), 36'd0);
        check("edgeArbData", 36'(bus.arbDATAO),   36'o707070707070);
        bus.busACKI = 1'b0; bus.busDATAI = '0; bus.cpuREQI = 1'b0;
        tick(); tick();

        // reset during BUSY drops the transaction; request regranted after release
        bus.cpuREQI = 1'b1;
        tick();
        check("rstPreGrant", 36'(bus.arbGRANT), 36'(3'b001));
        tick();
        rst = 1'b1;
        tick();
        checkIdle("midReset");
        rst = 1'b0;
        tick();
        check("rstRegrant", 36'(bus.arbGRANT), 36'(3'b001));
        expectEvt(3'b001, 1'b0, 36'o246024602460);
        bus.busACKI = 1'b1; bus.busDATAI = 36'o246024602460;
        tick();
        check("rstAck", 36'(bus.cpuACKO), 36'd1);
        bus.busACKI = 1'b0; bus.busDATAI = '0; bus.cpuREQI = 1'b0;
        tick(); tick();

        check("sbEmpty", 36'(expQ.size()), 36'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
